// File: rtl/tt_um_popcount_enum.sv
// rtl/tt_um_popcount_enum.sv - enumerates every WIDTH-bit pattern of a requested weight
// Optional POPENUM_DESC_EN: enumerate in descending numeric order instead of ascending.
module tt_um_popcount_enum #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH:0]   req_onehot,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic [WIDTH-1:0] pat_data,
  output logic             pat_last,
  output logic             busy,
  output logic             err
);

  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [WIDTH:0]   cand, cand_nxt, cand_start, cand_step;
  logic [WIDTH-1:0] pat_data_nxt, last_pat;
  logic             pat_last_nxt, err_nxt;
  logic [KW-1:0]    cand_ones, req_bin;
  logic [KW:0]      req_ones;

  always_comb begin
    cand_ones = '0;
    for (int i = 0; i < WIDTH; i++) cand_ones = cand_ones + KW'(cand[i]);
    req_ones = '0;
    req_bin  = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      req_ones = req_ones + (KW + 1)'(req_onehot[i]);
      if (req_onehot[i]) req_bin = KW'(i);
    end
  end

`ifdef POPENUM_DESC_EN
  // Descending: the final pattern has the k low bits set.
  assign cand_start = {1'b0, {WIDTH{1'b1}}};
  assign cand_step  = cand - (WIDTH + 1)'(1);
  assign last_pat   = ~({WIDTH{1'b1}} << k);
`else
  // Ascending: the final pattern has the k high bits set.
  assign cand_start = '0;
  assign cand_step  = cand + (WIDTH + 1)'(1);
  assign last_pat   = ~({WIDTH{1'b1}} >> k);
`endif

  assign req_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign pat_valid = (state == EMIT);

  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    cand_nxt     = cand;
    pat_data_nxt = pat_data;
    pat_last_nxt = pat_last;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_ones == (KW + 1)'(1)) begin
            k_nxt     = req_bin;
            cand_nxt  = cand_start;
            state_nxt = SCAN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        // cand[WIDTH] only sets if the space is exhausted; bail out rather than spin.
        if (cand[WIDTH]) begin
          state_nxt = IDLE;
        end else if (cand_ones == k) begin
          pat_data_nxt = cand[WIDTH-1:0];
          pat_last_nxt = (cand[WIDTH-1:0] == last_pat);
          state_nxt    = EMIT;
        end else begin
          cand_nxt = cand_step;
        end
      end
      EMIT: begin
        if (pat_ready) begin
          if (pat_last) begin
            state_nxt = IDLE;
          end else begin
            cand_nxt  = cand_step;
            state_nxt = SCAN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      cand     <= '0;
      pat_data <= '0;
      pat_last <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      cand     <= cand_nxt;
      pat_data <= pat_data_nxt;
      pat_last <= pat_last_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_tt_um_popcount_enum.sv
// tb/tb_tt_um_popcount_enum.sv - directed bench for tt_um_popcount_enum (WIDTH=4)
module tb_tt_um_popcount_enum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_onehot = '0;
  logic       pat_valid;
  logic       pat_ready = 1'b0;
  logic [3:0] pat_data;
  logic       pat_last;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  tt_um_popcount_enum #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_onehot(req_onehot), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .pat_last(pat_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [4:0] oh);
    req_onehot = oh;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Wait for pat_valid counting negedges, check pattern and latency, then step one cycle.
  task automatic get_pat(input string tag, input logic [3:0] d, input logic l, input int lat);
    int n = 0;
    while (pat_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(pat_valid), 32'd1);
    check({tag, "_data"}, 32'(pat_data), 32'(d));
    check({tag, "_last"}, 32'(pat_last), 32'(l));
    if (lat >= 0) check({tag, "_lat"}, 32'(n), 32'(lat));
    @(negedge clk);
  endtask

  logic [3:0] seq [6];
  int         lat [6];

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(pat_valid), 32'd0);
    check("rst_data", 32'(pat_data), 32'd0);
    check("rst_last", 32'(pat_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    pat_ready = 1'b1;

`ifdef POPENUM_DESC_EN
    seq = '{4'b1100, 4'b1010, 4'b1001, 4'b0110, 4'b0101, 4'b0011};
    lat = '{4, 2, 1, 3, 1, 2};
    send_req(5'b00100);
    for (int i = 0; i < 6; i++) get_pat($sformatf("d2_%0d", i), seq[i], i == 5, lat[i]);
    check("d2_busy", 32'(busy), 32'd0);
    send_req(5'b00001);
    get_pat("d0", 4'b0000, 1'b1, 16);
    send_req(5'b10000);
    get_pat("d4", 4'b1111, 1'b1, 1);
    check("d4_ready", 32'(req_ready), 32'd1);
`else
    seq = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
    lat = '{4, 2, 1, 3, 1, 2};
    send_req(5'b00100);
    for (int i = 0; i < 6; i++) get_pat($sformatf("w2_%0d", i), seq[i], i == 5, lat[i]);
    check("w2_busy", 32'(busy), 32'd0);
    check("w2_ready", 32'(req_ready), 32'd1);

    send_req(5'b00001);
    get_pat("w0", 4'b0000, 1'b1, 1);
    send_req(5'b10000);
    get_pat("w4", 4'b1111, 1'b1, 16);
    check("w4_busy", 32'(busy), 32'd0);

    send_req(5'b00110);
    check("err2_pulse", 32'(err), 32'd1);
    check("err2_ready", 32'(req_ready), 32'd1);
    check("err2_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("err2_clear", 32'(err), 32'd0);
    check("err2_nopat", 32'(pat_valid), 32'd0);
    send_req(5'b00000);
    check("err0_pulse", 32'(err), 32'd1);
    check("err0_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("err0_clear", 32'(err), 32'd0);
    check("err0_nopat", 32'(pat_valid), 32'd0);

    pat_ready = 1'b0;
    send_req(5'b00010);
    get_pat("w1_0", 4'b0001, 1'b0, 2);
    req_onehot = 5'b10000;
    req_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold%0d_valid", i), 32'(pat_valid), 32'd1);
      check($sformatf("hold%0d_data", i), 32'(pat_data), 32'd1);
      check($sformatf("hold%0d_ready", i), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    pat_ready = 1'b1;
    @(negedge clk);
    get_pat("w1_1", 4'b0010, 1'b0, 1);
    get_pat("w1_2", 4'b0100, 1'b0, 2);
    get_pat("w1_3", 4'b1000, 1'b1, 4);
    check("w1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("w1_idle", 32'(pat_valid), 32'd0);

    send_req(5'b01000);
    get_pat("w3_0", 4'b0111, 1'b0, 8);
    get_pat("w3_1", 4'b1011, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(pat_valid), 32'd0);
    check("mrst_data", 32'(pat_data), 32'd0);
    check("mrst_last", 32'(pat_last), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_ready", 32'(req_ready), 32'd1);
    check("mrst_err2", 32'(err), 32'd0);
    send_req(5'b01000);
    get_pat("w3r_0", 4'b0111, 1'b0, 8);
    get_pat("w3r_1", 4'b1011, 1'b0, 4);
    get_pat("w3r_2", 4'b1101, 1'b0, 2);
    get_pat("w3r_3", 4'b1110, 1'b1, 1);
    check("w3r_busy", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_popcount_enum.md
# tt_um_popcount_enum

Weight-driven pattern generator: the reverse of the team's 4-input weight classifier, which maps a word to a one-hot "number of ones" flag. This block accepts a one-hot weight request and emits, one per handshake, every WIDTH-bit pattern with exactly that many ones, in numeric order. It is the stimulus source feeding classifier instances and the golden-pattern generator for on-chip self-check.

## Interface
- WIDTH, 4, pattern width; legal range 2..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE.
- req_onehot  in  WIDTH+1  requested weight; bit k set means weight k (bit 0 means "no ones", bit WIDTH means "all ones").
- pat_valid  out  1  pattern available.
- pat_ready  in  1  consumer accepts the pattern.
- pat_data  out  WIDTH  current pattern.
- pat_last  out  1  pat_data is the final pattern of the request.
- busy  out  1  state is not IDLE.
- err  out  1  one-cycle pulse when a request is rejected.

## Operation
- State register: IDLE, SCAN, EMIT. Other registers:
  - weight k, binary, width clog2(WIDTH+1).
  - candidate counter cand, WIDTH+1 bits so it cannot wrap.
  - output registers pat_data and pat_last.
- IDLE:
  - req_ready=1.
  - On req_valid, check req_onehot:
    - exactly one bit set: load k, cand=0, go to SCAN.
    - zero bits or more than one bit set: err=1 for the next cycle, stay in IDLE, no pattern emitted.
- SCAN:
  - Each cycle, compute popcount(cand[WIDTH-1:0]) combinationally.
  - Match (popcount == k): register pat_data=cand, pat_last=(cand == the k highest bits set), go to EMIT.
  - No match: cand += 1.
  - For a legal k a match always exists before cand reaches 2^WIDTH.
- EMIT:
  - pat_valid=1; pat_data and pat_last stay stable until pat_ready.
  - On a pat_valid&&pat_ready edge:
    - pat_last=1: go to IDLE.
    - pat_last=0: cand += 1, go to SCAN.
- Total patterns per request = C(WIDTH,k). For WIDTH=4 that is 1, 4, 6, 4, 1 for k=0..4.
- Requests are never queued. req_ready=0 while busy, and req_valid is ignored during that time.
- Asserting rst_n low mid-enumeration abandons the request at once. No partial completion and no err pulse.
- Reset values:
  - state IDLE, cand 0, k 0.
  - pat_valid 0, pat_data 0, pat_last 0, busy 0, err 0.
  - req_ready is 1 once reset is released.

## Timing
- Request acceptance edge = A. The first matching candidate value = c.
- pat_valid is high in the cycle after edge A+c+1.
  - k=0: pat_valid after A+1.
  - k=WIDTH: pat_valid after A+2^WIDTH.
- Consumption edge = H, next matching candidate = c'. The next pat_valid is high after edge H+(c'-c).
  - Adjacent matches therefore produce pat_valid one cycle low between patterns. No back-to-back streaming.
- err goes high on the edge after acceptance of the bad request and low on the following edge.
- busy goes 1 on edge A and goes 0 on the edge that consumes the pat_last pattern. req_ready is high again in the same cycle that busy returns to 0.
- pat_ready is sampled only in EMIT; it has no effect in other states.

## Configuration
- POPENUM_DESC_EN undefined: ascending enumeration as above.
- POPENUM_DESC_EN defined: descending enumeration.
  - cand starts at 2^WIDTH-1 and decrements.
  - pat_last when cand equals the low k bits set; for k=0 the pattern is 0.
  - The first pattern appears after A+1+(2^WIDTH-1-c), where c is now the first match counting down from 2^WIDTH-1.
  - The handshake, err and reset behaviour are identical.

## Test plan
- WIDTH=4, req_onehot=5'b00100, pat_ready=1 → 0011, 0101, 0110, 1001, 1010, 1100 in order; pat_last only on 1100; then IDLE and req_ready=1.
- req_onehot=5'b00001 → a single pattern 0000 with pat_last=1, pat_valid after A+1. req_onehot=5'b10000 → 1111 with pat_last=1, pat_valid after A+16.
- req_onehot=5'b00110, then separately 5'b00000 → err pulses one cycle each; pat_valid never asserts; req_ready stays 1.
- Weight 1, pat_ready held low 3 cycles on the first pattern → pat_data=0001 stays stable and pat_valid stays high; then 0010, 0100, 1000 follow; a req_valid issued mid-run is ignored.
- Weight 3, rst_n pulsed low after 2 patterns → all outputs 0 immediately; after release req_ready=1, and a new weight-3 request restarts from 0111.
- POPENUM_DESC_EN defined, weight 2 → 1100, 1010, 1001, 0110, 0101, 0011; pat_last on 0011.
